// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling,
// sticky valid/framing-error flags and break handling after a bad stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_byte;
    logic             r_rx_dv;
    logic             r_frame_err;

    logic             w_cnt_half;
    logic             w_cnt_last;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_load_byte;
    logic             w_set_err;
    logic             w_clr_flags;

    assign w_cnt_half = (r_cnt == CNT_HALF);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!r_rx_sync) w_state_next = StStart;
            end
            StStart: begin
                if (w_cnt_half) w_state_next = r_rx_sync ? StIdle : StData;
            end
            StData: begin
                if (w_cnt_last && (r_bit_idx == 3'd7)) w_state_next = StStop;
            end
            StStop: begin
                if (w_cnt_last) w_state_next = r_rx_sync ? StIdle : StWaitHigh;
            end
            StWaitHigh: begin
                // Hold off until the line returns high so a break is not a start bit.
                if (r_rx_sync) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_load_byte = 1'b0;
        w_set_err   = 1'b0;
        w_clr_flags = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_clr   = 1'b1;
                w_clr_flags = !r_rx_sync;
            end
            StStart: begin
                w_cnt_clr = w_cnt_half;
            end
            StData: begin
                w_cnt_clr  = w_cnt_last;
                w_shift_en = w_cnt_last;
            end
            StStop: begin
                w_cnt_clr   = w_cnt_last;
                w_load_byte = w_cnt_last && r_rx_sync;
                w_set_err   = w_cnt_last && !r_rx_sync;
            end
            StWaitHigh: begin
                w_cnt_clr = 1'b1;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_byte   <= 8'h00;
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta <= i_RX_Serial;
            r_rx_sync <= r_rx_meta;
            r_cnt     <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            // Index wraps 7 -> 0, leaving it ready for the next frame.
            if (w_shift_en) begin
                r_shift[r_bit_idx] <= r_rx_sync;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if (w_load_byte) begin
                r_rx_byte <= r_shift;
                r_rx_dv   <= 1'b1;
            end
            if (w_set_err) begin
                r_frame_err <= 1'b1;
            end
            if (w_clr_flags) begin
                r_rx_dv     <= 1'b0;
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_RX_DV        = r_rx_dv;
    assign o_RX_Byte      = r_rx_byte;
    assign o_RX_Frame_Err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks with a byte scoreboard queue.
module tb_uart_rx;

    localparam int CLKS = 217;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       ferr;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_RX_Serial   (rx),
        .o_RX_DV       (dv),
        .o_RX_Byte     (rx_byte),
        .o_RX_Frame_Err(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tx_bit(input logic b);
        rx = b;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic stop_ok);
        if (stop_ok) exp_q.push_back(d);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(d[i]);
        tx_bit(stop_ok);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CLKS) @(negedge clk);
    endtask

    task automatic pop_exp(output logic [7:0] e);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got empty queue, required an entry");
            e = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({dv, ferr, rx_byte} !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs: got dv=%b err=%b byte=%h required 0 0 00",
                     dv, ferr, rx_byte);
        end
        rst = 1'b0;
        repeat (2 * CLKS) @(negedge clk);
        checks++;
        if ({dv, ferr, rx_byte} !== 10'h000) begin
            errors++;
            $display("FAIL idle_after_reset: got dv=%b err=%b byte=%h required 0 0 00",
                     dv, ferr, rx_byte);
        end
    endtask

    task automatic test_single_byte;
        int         lat;
        logic [7:0] e;
        lat = 0;
        fork
            tx_frame(8'h55, 1'b1);
            begin
                while (dv !== 1'b1 && lat < 3000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 2058 || lat > 2066) begin
            errors++;
            $display("FAIL dv_latency: got %0d clocks required 2058..2066", lat);
        end
        repeat (2 * CLKS) @(negedge clk);
        pop_exp(e);
        checks++;
        if (dv !== 1'b1 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL single_flags: got dv=%b err=%b required 1 0", dv, ferr);
        end
        checks++;
        if (rx_byte !== e) begin
            errors++;
            $display("FAIL single_byte: got %h required %h", rx_byte, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        logic [7:0] d;
        tx_frame(8'h00, 1'b1);
        pop_exp(e);
        checks++;
        if (dv !== 1'b1 || rx_byte !== e) begin
            errors++;
            $display("FAIL b2b_first: got dv=%b byte=%h required 1 %h", dv, rx_byte, e);
        end
        d = 8'hFF;
        exp_q.push_back(d);
        tx_bit(1'b0);
        checks++;
        if (dv !== 1'b0 || rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL b2b_dv_drop: got dv=%b byte=%h required 0 00", dv, rx_byte);
        end
        for (int i = 0; i < 8; i++) tx_bit(d[i]);
        tx_bit(1'b1);
        idle_bits(2);
        pop_exp(e);
        checks++;
        if (dv !== 1'b1 || rx_byte !== e) begin
            errors++;
            $display("FAIL b2b_second: got dv=%b byte=%h required 1 %h", dv, rx_byte, e);
        end
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        repeat (CLKS / 4) @(negedge clk);
        idle_bits(2);
        checks++;
        if (dv !== 1'b0 || ferr !== 1'b0 || rx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL glitch: got dv=%b err=%b byte=%h required 0 0 ff",
                     dv, ferr, rx_byte);
        end
    endtask

    task automatic test_frame_err;
        logic [7:0] e;
        tx_frame(8'hA5, 1'b0);
        rx = 1'b0;
        repeat (2 * CLKS) @(negedge clk);
        checks++;
        if (ferr !== 1'b1 || dv !== 1'b0 || rx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL frame_err: got err=%b dv=%b byte=%h required 1 0 ff",
                     ferr, dv, rx_byte);
        end
        idle_bits(2);
        checks++;
        if (ferr !== 1'b1 || dv !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_sticky: got err=%b dv=%b required 1 0", ferr, dv);
        end
        tx_frame(8'h3C, 1'b1);
        idle_bits(2);
        pop_exp(e);
        checks++;
        if (dv !== 1'b1 || ferr !== 1'b0 || rx_byte !== e) begin
            errors++;
            $display("FAIL after_err: got dv=%b err=%b byte=%h required 1 0 %h",
                     dv, ferr, rx_byte, e);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        logic [7:0] e;
        d = 8'h81;
        tx_bit(1'b0);
        for (int i = 0; i < 4; i++) tx_bit(d[i]);
        rx = d[4];
        repeat (CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dv, ferr, rx_byte} !== 10'h000) begin
            errors++;
            $display("FAIL midframe_reset: got dv=%b err=%b byte=%h required 0 0 00",
                     dv, ferr, rx_byte);
        end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        checks++;
        if ({dv, ferr, rx_byte} !== 10'h000) begin
            errors++;
            $display("FAIL partial_discard: got dv=%b err=%b byte=%h required 0 0 00",
                     dv, ferr, rx_byte);
        end
        tx_frame(d, 1'b1);
        idle_bits(2);
        pop_exp(e);
        checks++;
        if (dv !== 1'b1 || ferr !== 1'b0 || rx_byte !== e) begin
            errors++;
            $display("FAIL post_reset_rx: got dv=%b err=%b byte=%h required 1 0 %h",
                     dv, ferr, rx_byte, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rx     = 1'b1;
        rst    = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
